// File: rtl/memory_bank_1r1w_arbiter.sv
// memory_bank_1r1w_arbiter
// Shares one byte-enabled 1R1W bank between NUM_REQ readers and NUM_REQ
// writers. The read and write ports each have their own round-robin arbiter.
// Read responses come back tagged with the requester id one cycle after issue.
// Optional macro MEMORY_BANK_ARBITER_INIT_EN: after reset, zero-fill the bank
// (SIZE cycles) before granting any requests.
module memory_bank_1r1w_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4,
    localparam int DW        = NB_COL * COL_WIDTH,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            rd_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_address,
    output logic [NUM_REQ-1:0]            rd_ready,
    input  logic [NUM_REQ-1:0]            wr_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_address,
    input  logic [NUM_REQ*DW-1:0]         wr_data,
    input  logic [NUM_REQ*NB_COL-1:0]     wr_byte_en,
    output logic [NUM_REQ-1:0]            wr_ready,
    output logic                          resp_valid,
    output logic [IDW-1:0]                resp_id,
    output logic [DW-1:0]                 resp_data,
    output logic                          init_done,
    output logic                          mem_read_enable,
    output logic [ADDR_WIDTH-1:0]         mem_read_address,
    output logic [NB_COL-1:0]             mem_write_enable,
    output logic [ADDR_WIDTH-1:0]         mem_write_address,
    output logic [DW-1:0]                 mem_write_data,
    input  logic [DW-1:0]                 mem_read_data
);

    // First requester at or above ptr (wrapping) that is requesting.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDW-1:0] ptr,
                                               output logic found);
        int j;
        found   = 1'b0;
        rr_pick = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                rr_pick = IDW'(j);
            end
        end
    endfunction

    // Pointer moves just past the granted requester, wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
        return (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + IDW'(1);
    endfunction

    logic [IDW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDW-1:0] rd_idx, wr_idx;
    logic           rd_found, wr_found;
    logic           run_en;
    logic           resp_valid_q;
    logic [IDW-1:0] resp_id_q;
    logic           init_done_q, init_done_d;

`ifdef MEMORY_BANK_ARBITER_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    init_wr;

    // State register: reset restarts the fill from row 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: walk every row once, then hand the bank to the requesters.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == ADDR_WIDTH'(SIZE - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: which phase owns the bank this cycle.
    always_comb begin
        run_en      = !reset && (state_q == ST_RUN);
        init_wr     = !reset && (state_q == ST_INIT);
        init_done_d = init_done_q || (state_d == ST_RUN);
    end
`else
    // Without the fill phase the bank is usable as soon as reset drops.
    always_comb begin
        run_en      = !reset;
        init_done_d = 1'b1;
    end
`endif

    // Round-robin pick for both ports against their own pointers.
    always_comb begin
        rd_idx = rr_pick(rd_valid, rd_ptr_q, rd_found);
        wr_idx = rr_pick(wr_valid, wr_ptr_q, wr_found);
    end

    // Pointers advance only on a grant; with no request they hold.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (run_en && rd_found) rd_ptr_d = next_ptr(rd_idx);
        if (run_en && wr_found) wr_ptr_d = next_ptr(wr_idx);
    end

    // Grants and bank drive; addresses/data follow the pick, enables are gated.
    always_comb begin
        rd_ready          = '0;
        wr_ready          = '0;
        mem_read_enable   = 1'b0;
        mem_read_address  = rd_address[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_enable  = '0;
        mem_write_address = wr_address[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_data    = wr_data[int'(wr_idx)*DW +: DW];
        if (run_en) begin
            if (rd_found) begin
                rd_ready[rd_idx] = 1'b1;
                mem_read_enable  = 1'b1;
            end
            if (wr_found) begin
                // An all-zero byte enable still consumes the grant.
                wr_ready[wr_idx] = 1'b1;
                mem_write_enable = wr_byte_en[int'(wr_idx)*NB_COL +: NB_COL];
            end
        end
`ifdef MEMORY_BANK_ARBITER_INIT_EN
        else if (init_wr) begin
            mem_write_enable  = '1;
            mem_write_address = init_cnt_q;
            mem_write_data    = '0;
        end
`endif
    end

    // Pointers and the response tag pipeline; one response per issued read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            init_done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            resp_valid_q <= mem_read_enable;
            if (mem_read_enable) resp_id_q <= rd_idx;
            init_done_q  <= init_done_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = mem_read_data;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_memory_bank_1r1w_arbiter.sv
// Testbench for memory_bank_1r1w_arbiter (NUM_REQ=4, SIZE=16, 32-bit rows).
// A write-first bank model sits behind the DUT. Read expectations are queued
// at issue time and a negedge monitor pops them when resp_valid is seen.
module tb_memory_bank_1r1w_arbiter;

    localparam int NR = 4;
    localparam int SZ = 16;
    localparam int AW = 4;
    localparam int NB = 4;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     rd_valid;
    logic [NR*AW-1:0]  rd_address;
    logic [NR-1:0]     rd_ready;
    logic [NR-1:0]     wr_valid;
    logic [NR*AW-1:0]  wr_address;
    logic [NR*DW-1:0]  wr_data;
    logic [NR*NB-1:0]  wr_byte_en;
    logic [NR-1:0]     wr_ready;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [DW-1:0]     resp_data;
    logic              init_done;
    logic              mem_read_enable;
    logic [AW-1:0]     mem_read_address;
    logic [NB-1:0]     mem_write_enable;
    logic [AW-1:0]     mem_write_address;
    logic [DW-1:0]     mem_write_data;
    logic [DW-1:0]     mem_read_data;

    memory_bank_1r1w_arbiter #(
        .NUM_REQ(NR), .SIZE(SZ), .COL_WIDTH(8), .NB_COL(NB)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_valid(rd_valid), .rd_address(rd_address), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data),
        .wr_byte_en(wr_byte_en), .wr_ready(wr_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .init_done(init_done),
        .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Round-robin vectors: requesters 0,1,3 hold requests on rows 1,2,4.
    int          rr_ids [6]  = '{0, 1, 3, 0, 1, 3};
    logic [3:0]  rr_addr [4] = '{4'd1, 4'd2, 4'd0, 4'd4};
    logic [31:0] rr_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h4444_4444};

    // Write-first bank model.
    logic [31:0] bank_mem [SZ];

    initial begin
        for (int i = 0; i < SZ; i++) begin
`ifdef MEMORY_BANK_ARBITER_INIT_EN
            bank_mem[i] <= 32'hA5A5_A5A5;
`else
            bank_mem[i] <= 32'h0;
`endif
        end
    end

    function automatic logic [31:0] bank_read();
        logic [31:0] v;
        v = bank_mem[mem_read_address];
        if (mem_write_address == mem_read_address)
            for (int b = 0; b < NB; b++)
                if (mem_write_enable[b]) v[b*8 +: 8] = mem_write_data[b*8 +: 8];
        return v;
    endfunction

    always @(posedge clock) begin
        for (int b = 0; b < NB; b++)
            if (mem_write_enable[b] === 1'b1)
                bank_mem[mem_write_address][b*8 +: 8] <= mem_write_data[b*8 +: 8];
        if (mem_read_enable === 1'b1) mem_read_data <= bank_read();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest queued expectation.
    always @(negedge clock) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_id", 32'(resp_id), 32'(mon_e.id));
                check("resp_data", resp_data, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear();
        rd_valid = '0;
        wr_valid = '0;
    endtask

    task automatic set_rd(input int id, input logic [3:0] addr);
        rd_valid[id]           = 1'b1;
        rd_address[id*AW +: AW] = addr;
    endtask

    task automatic set_wr(input int id, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
        wr_valid[id]             = 1'b1;
        wr_address[id*AW +: AW]  = addr;
        wr_data[id*DW +: DW]     = data;
        wr_byte_en[id*NB +: NB]  = be;
    endtask

    task automatic chk_rd(input int id, input logic [3:0] addr, input logic [31:0] data);
        exp_t e;
        check("rd_ready", 32'(rd_ready), 32'(1 << id));
        check("mem_read_enable", 32'(mem_read_enable), 32'd1);
        check("mem_read_address", 32'(mem_read_address), 32'(addr));
        e.id   = 2'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk_wr(input int id, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
        check("wr_ready", 32'(wr_ready), 32'(1 << id));
        check("mem_write_enable", 32'(mem_write_enable), 32'(be));
        check("mem_write_address", 32'(mem_write_address), 32'(addr));
        check("mem_write_data", mem_write_data, data);
    endtask

    task automatic chk_idle();
        check("idle_rd_ready", 32'(rd_ready), 32'd0);
        check("idle_wr_ready", 32'(wr_ready), 32'd0);
        check("idle_mem_read_enable", 32'(mem_read_enable), 32'd0);
    endtask

`ifdef MEMORY_BANK_ARBITER_INIT_EN
    // Fill phase: requests pending but ignored, one zero write per row.
    task automatic init_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NR; i++) set_rd(i, 4'd0);
            for (int i = 0; i < NR; i++) set_wr(i, 4'd0, 32'hFFFF_FFFF, 4'hF);
            #1;
            check("init_we", 32'(mem_write_enable), 32'hF);
            check("init_addr", 32'(mem_write_address), 32'(c));
            check("init_data", mem_write_data, 32'h0);
            check("init_done_low", 32'(init_done), 32'd0);
            chk_idle();
            clear();
            tick();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        rd_valid   = '1;
        wr_valid   = '1;
        rd_address = '0;
        wr_address = '0;
        wr_data    = '1;
        wr_byte_en = '1;

        // Reset holds everything quiet even with all requests asserted.
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk_idle();
            check("rst_mem_we", 32'(mem_write_enable), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_id", 32'(resp_id), 32'd0);
            check("rst_init_done", 32'(init_done), 32'd0);
        end
        reset = 1'b0;
        clear();

`ifdef MEMORY_BANK_ARBITER_INIT_EN
        // Abort the fill at row 8, then watch it restart from row 0.
        init_cycles(8);
        reset = 1'b1;
        set_rd(0, 4'd0);
        #1;
        check("midinit_rst_we", 32'(mem_write_enable), 32'd0);
        chk_idle();
        tick();
        #1;
        check("midinit_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        clear();
        init_cycles(SZ);
        #1;
        check("init_done_high", 32'(init_done), 32'd1);
        check("post_init_we", 32'(mem_write_enable), 32'd0);
        set_rd(3, 4'd7);
        #1;
        chk_rd(3, 4'd7, 32'h0);
        tick();
        clear();
`else
        tick();
        #1;
        check("init_done_high", 32'(init_done), 32'd1);
`endif

        // Seed rows 1, 2, 4.
        set_wr(0, 4'd1, 32'h1111_1111, 4'hF); #1; chk_wr(0, 4'd1, 32'h1111_1111, 4'hF); tick(); clear();
        set_wr(1, 4'd2, 32'h2222_2222, 4'hF); #1; chk_wr(1, 4'd2, 32'h2222_2222, 4'hF); tick(); clear();
        set_wr(3, 4'd4, 32'h4444_4444, 4'hF); #1; chk_wr(3, 4'd4, 32'h4444_4444, 4'hF); tick(); clear();

        // Round-robin among 0,1,3 with back-to-back responses.
        set_rd(0, 4'd1); set_rd(1, 4'd2); set_rd(3, 4'd4);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk_rd(rr_ids[k], rr_addr[rr_ids[k]], rr_data[rr_ids[k]]);
            if (k > 0) check("rr_resp_valid", 32'(resp_valid), 32'd1);
            tick();
        end
        clear();

        // Parallel read and write in one cycle.
        set_wr(2, 4'd5, 32'hDEAD_BEEF, 4'hF); set_rd(1, 4'd9);
        #1;
        chk_wr(2, 4'd5, 32'hDEAD_BEEF, 4'hF);
        chk_rd(1, 4'd9, 32'h0);
        tick(); clear();
        set_rd(0, 4'd5); #1; chk_rd(0, 4'd5, 32'hDEAD_BEEF); tick(); clear();

        // Partial byte enables, then a zero-enable write that still wins a grant.
        set_wr(0, 4'd3, 32'hAABB_CCDD, 4'b0101); #1; chk_wr(0, 4'd3, 32'hAABB_CCDD, 4'b0101); tick(); clear();
        set_rd(2, 4'd3); #1; chk_rd(2, 4'd3, 32'h00BB_00DD); tick(); clear();
        set_wr(1, 4'd3, 32'hFFFF_FFFF, 4'b0000); set_wr(2, 4'd6, 32'h6666_6666, 4'b1000);
        #1; chk_wr(1, 4'd3, 32'hFFFF_FFFF, 4'b0000); tick();
        #1; chk_wr(2, 4'd6, 32'h6666_6666, 4'b1000); tick(); clear();

        // Same-row read and write: write-first bank returns the new data.
        set_wr(3, 4'd10, 32'h1234_5678, 4'hF); set_rd(3, 4'd10);
        #1;
        chk_wr(3, 4'd10, 32'h1234_5678, 4'hF);
        chk_rd(3, 4'd10, 32'h1234_5678);
        tick(); clear();

        // Row 3 untouched by the zero-enable write; row 6 only top lane.
        set_rd(0, 4'd3); set_rd(1, 4'd6);
        #1; chk_rd(0, 4'd3, 32'h00BB_00DD); tick();
        #1; chk_rd(1, 4'd6, 32'h6600_0000); tick(); clear();
        #1; chk_idle(); tick();

        // Reset with a read pending: no grant, no response, pointers back to 0.
        set_rd(0, 4'd1);
        reset = 1'b1;
        #1;
        chk_idle();
        check("rst_run_we", 32'(mem_write_enable), 32'd0);
        tick();
        #1;
        check("rst_run_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_run_resp_id", 32'(resp_id), 32'd0);
        check("rst_run_init_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        clear();
`ifdef MEMORY_BANK_ARBITER_INIT_EN
        init_cycles(SZ);
        #1;
        check("reinit_done", 32'(init_done), 32'd1);
`endif
        for (int i = 0; i < NR; i++) set_rd(i, 4'd1);
        #1;
`ifdef MEMORY_BANK_ARBITER_INIT_EN
        chk_rd(0, 4'd1, 32'h0);
`else
        chk_rd(0, 4'd1, 32'h1111_1111);
`endif
        tick(); clear();

        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_bank_1r1w_arbiter.md
Name: memory_bank_1r1w_arbiter

Overview:
- Shares one byte-enabled, 1-read/1-write memory bank between NUM_REQ read requesters and NUM_REQ write requesters.
- Uses independent round-robin arbiters per port, so at most one read and one write are issued to the bank per cycle.
- Returns tagged read responses one cycle after issue.
- Optionally zero-fills the bank after reset before accepting traffic. Sits between cache/scratchpad clients and the bank instance.

Parameters:
NUM_REQ, 4, number of read requesters and of write requesters (>=2)
SIZE, 1024, bank depth in rows
ADDR_WIDTH, $clog2(SIZE), row address width
COL_WIDTH, 8, bits per byte lane
NB_COL, 4, byte lanes per row; row width DW = NB_COL*COL_WIDTH

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
rd_valid  in  NUM_REQ  per-requester read request
rd_address  in  NUM_REQ*ADDR_WIDTH  packed read addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_ready  out  NUM_REQ  one-hot read grant
wr_valid  in  NUM_REQ  per-requester write request
wr_address  in  NUM_REQ*ADDR_WIDTH  packed write addresses
wr_data  in  NUM_REQ*DW  packed write data
wr_byte_en  in  NUM_REQ*NB_COL  packed byte enables
wr_ready  out  NUM_REQ  one-hot write grant
resp_valid  out  1  read data valid
resp_id  out  $clog2(NUM_REQ)  index of the requester owning resp_data
resp_data  out  DW  read data, mirrors bank read_data
init_done  out  1  high once the bank is usable
mem_read_enable  out  1  to bank
mem_read_address  out  ADDR_WIDTH  to bank
mem_write_enable  out  NB_COL  to bank
mem_write_address  out  ADDR_WIDTH  to bank
mem_write_data  out  DW  to bank
mem_read_data  in  DW  from bank; valid the cycle after mem_read_enable

Behaviour:
- Clock and reset:
  - Single clock domain, port `clock`.
  - Reset port `reset` is synchronous, active-high.
  - While reset is high: rd_ready=0, wr_ready=0, mem_read_enable=0, mem_write_enable=0.
  - Registered outputs reset to: resp_valid=0, resp_id=0, init_done=0.
  - Both round-robin pointers reset to requester 0.
- FSM: INIT -> RUN.
  - Reset enters INIT (or RUN, see Optional Feature).
  - INIT: init counter 0..SIZE-1. Each cycle drives mem_write_enable=all ones, mem_write_address=counter, mem_write_data=0.
  - INIT: all ready=0, no reads issued.
  - On counter==SIZE-1 the write is issued, then the FSM moves to RUN next cycle. INIT lasts exactly SIZE cycles.
  - init_done rises on the first RUN cycle and stays high until reset.
- RUN arbitration:
  - Read and write arbiters are independent; a read and a write may be issued in the same cycle.
  - Grant is combinational: the first valid requester scanning from the pointer upward, wrapping at NUM_REQ.
  - rd_ready/wr_ready equal the grant. A transfer occurs on valid&&ready.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
  - With no valid requester, the pointer holds and enables are 0.
- Bank drive:
  - mem_read_enable = any read grant; mem_read_address = granted address.
  - mem_write_enable = granted wr_byte_en (all-zero byte enables still consume the grant).
  - Write address and data come from the granted requester.
  - Ungranted cycles: addresses/data are don't-care, enables are 0.
- Response:
  - resp_valid and resp_id are registered one cycle after a read grant.
  - resp_data = mem_read_data combinationally.
  - Latency from grant to resp_valid = 1 cycle, fully pipelined: one response per cycle.
- Same-address read and write in one cycle: the controller does not stall. resp_data is whatever the bank returns (new data when the bank is write-first).
- Reset mid-operation:
  - A reset during INIT restarts the counter at 0.
  - A read granted in the cycle reset is sampled produces no resp_valid.

Optional Feature:
- Macro: MEMORY_BANK_ARBITER_INIT_EN.
- Defined: INIT zero-fill as above; init_done rises SIZE cycles after reset deasserts.
- Undefined: no INIT state or counter. The FSM resets directly to RUN, init_done is 1 on the first cycle after reset deasserts, and requests are granted immediately.

Test Plan:
- Init fill (macro on, SIZE=16): release reset -> 16 consecutive writes to addresses 0..15 with data 0 and enable 4'hF. init_done=1 at cycle 16. A read of address 7 returns 0.
- Round-robin: requesters 0,1,3 hold rd_valid continuously -> grants in order 0,1,3,0,1,3. resp_id follows one cycle later. resp_valid stays high every cycle.
- Parallel read/write: wr req 2 writes 32'hDEADBEEF to address 5 while rd req 1 reads address 9 in the same cycle -> both granted. The next cycle resp_id=1 with address 9 contents. A later read of address 5 returns 32'hDEADBEEF.
- Byte enables: a write of 32'hAABBCCDD with byte enable 4'b0101 to zeroed address 3 -> a read returns 32'h00BB00DD.
- Same-address collision: write 32'h12345678 and read of address 10 in one cycle -> resp_data = 32'h12345678 (write-first bank).
- Reset mid-INIT at counter 8 -> the counter restarts at 0. init_done rises SIZE cycles after this release. No resp_valid is produced for the read in flight when reset is sampled.
